// File: rtl/drac_adc_pkg.sv
// drac_adc_pkg
// Shared definitions for the DRAC motor-current ADC capture front end.
//   - adc_state_e    : capture sequencer state encoding
//   - *_DEF          : default timing constants at 49.152 MHz sysclk
//   - bit_cnt_width  : width of a counter that must hold 0..DATA_WIDTH
package drac_adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    QUIET = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } adc_state_e;

  localparam int NUM_CH_DEF       = 10;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int CONV_CYCLES_DEF  = 40;
  localparam int QUIET_CYCLES_DEF = 2;
  localparam int SCK_HALF_DEF     = 2;

  // The bit counter counts SCK rising edges up to and including DATA_WIDTH.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/drac_adc_sck_gen.sv
// drac_adc_sck_gen
// ADC serial clock divider. While enabled it produces SCK_HALF sysclk cycles
// low followed by SCK_HALF cycles high, repeating. Disabling or reset returns
// it to the start of a low phase with sck low.
// Ports:
//   sysclk          in   system clock
//   reset           in   synchronous active-high reset
//   en_i            in   run the divider (high only while shifting)
//   sck_o           out  registered SCK level, idle low
//   rise_strobe_o   out  high on the sysclk cycle before SCK rises
//   sample_strobe_o out  high on the last sysclk cycle of each SCK high phase
module drac_adc_sck_gen #(
  parameter int SCK_HALF = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_strobe_o,
  output logic sample_strobe_o
);

  localparam int CNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sck_q;
  logic             sck_d;
  logic             half_end_s;

  // Phase counter and SCK toggle decode.
  always_comb begin
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    half_end_s = (cnt_q == HALF_LAST);
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (half_end_s) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      sck_d = sck_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  // Strobes decode the current phase so the consumer acts on the same edge
  // at which SCK changes level.
  assign sck_o           = sck_q;
  assign rise_strobe_o   = en_i & half_end_s & ~sck_q;
  assign sample_strobe_o = en_i & half_end_s & sck_q;

endmodule

// File: rtl/drac_adc_capture.sv
// drac_adc_capture
// Serial ADC front end for the DRAC motor-current sample path. On an accepted
// start it holds CNV high for CONV_CYCLES, waits QUIET_CYCLES, then clocks
// DATA_WIDTH bits (MSB first) out of every ADC in parallel and presents the
// word-parallel result with a one-cycle valid strobe.
// Ports:
//   sysclk       in   system clock (49.152 MHz)
//   reset        in   synchronous active-high reset
//   start        in   sample request pulse
//   adc_cnv      out  ADC convert strobe
//   adc_sck      out  ADC serial clock level, idle low
//   adc_sdo      in   one serial data lane per channel
//   sample_data  out  channel k at [k*DATA_WIDTH +: DATA_WIDTH], raw code
//   sample_valid out  one-cycle strobe when sample_data updates
//   busy         out  high from start acceptance through the valid cycle
//   overrun_cnt  out  starts ignored while busy, saturating at 255
module drac_adc_capture
  import drac_adc_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CONV_CYCLES  = CONV_CYCLES_DEF,
  parameter int QUIET_CYCLES = QUIET_CYCLES_DEF,
  parameter int SCK_HALF     = SCK_HALF_DEF
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         adc_cnv,
  output logic                         adc_sck,
  input  logic [NUM_CH-1:0]            adc_sdo,
  output logic [NUM_CH*DATA_WIDTH-1:0] sample_data,
  output logic                         sample_valid,
  output logic                         busy,
  output logic [7:0]                   overrun_cnt
);

  localparam int BIT_W   = bit_cnt_width(DATA_WIDTH);
  localparam int CYC_MAX = (CONV_CYCLES > QUIET_CYCLES) ? CONV_CYCLES : QUIET_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] CONV_LAST  = CYC_W'(CONV_CYCLES - 1);
  localparam logic [CYC_W-1:0] QUIET_LAST = CYC_W'((QUIET_CYCLES > 0) ? (QUIET_CYCLES - 1) : 0);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH);

  adc_state_e state_q;
  adc_state_e state_d;

  logic [CYC_W-1:0] cyc_cnt_q;
  logic [CYC_W-1:0] cyc_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BIT_W-1:0] bit_cnt_d;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] shift_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] shift_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] sample_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] sample_d;

  logic       cnv_q;
  logic       cnv_d;
  logic       busy_q;
  logic       busy_d;
  logic       valid_q;
  logic       valid_d;
  logic [7:0] ovr_q;
  logic [7:0] ovr_d;

  logic sck_en_s;
  logic sck_s;
  logic rise_strobe_s;
  logic sample_strobe_s;
  logic ignore_s;

  assign sck_en_s = (state_q == SHIFT);

  drac_adc_sck_gen #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_gen (
    .sysclk          (sysclk),
    .reset           (reset),
    .en_i            (sck_en_s),
    .sck_o           (sck_s),
    .rise_strobe_o   (rise_strobe_s),
    .sample_strobe_o (sample_strobe_s)
  );

  // Sequencer next state, capture datapath and overrun counter.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    ovr_d     = ovr_q;
    ignore_s  = start & (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CONV;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      CONV: begin
        if (cyc_cnt_q == CONV_LAST) begin
          cyc_cnt_d = '0;
          state_d   = (QUIET_CYCLES == 0) ? SHIFT : QUIET;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      QUIET: begin
        if (cyc_cnt_q == QUIET_LAST) begin
          cyc_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      SHIFT: begin
        // bit_cnt counts SCK rising edges; the capture that follows the
        // DATA_WIDTH-th rise is the final bit.
        if (rise_strobe_s) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (sample_strobe_s) begin
          for (int k = 0; k < NUM_CH; k++) begin
            shift_d[k] = {shift_q[k][DATA_WIDTH-2:0], adc_sdo[k]};
          end
          if (bit_cnt_q == BIT_LAST) begin
            // Publish on the same edge as the last capture so data and the
            // valid strobe appear together in DONE.
            sample_d = shift_d;
            state_d  = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (ignore_s) begin
      if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end else begin
        ovr_d = ovr_q;
      end
    end else begin
      ovr_d = ovr_q;
    end

    // Outputs are registered from the next state so they align with it.
    cnv_d   = (state_d == CONV);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // Sequencer and datapath registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      cnv_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      cnv_q     <= cnv_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign adc_cnv      = cnv_q;
  assign adc_sck      = sck_s;
  assign sample_data  = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_drac_adc_capture.sv
// tb_drac_adc_capture
// Directed bench for drac_adc_capture. Instance A uses the default
// parameters with lane k returning 16'hA5A0+k; instance B uses
// DATA_WIDTH=12, SCK_HALF=1, QUIET_CYCLES=0 with all lanes high.
// Cycle c is the sysclk period whose closing edge samples inputs driven in
// it; outputs are viewed at the falling edge inside that period.
module tb_drac_adc_capture;

  localparam int NCH  = 10;
  localparam int DW_A = 16;
  localparam int DW_B = 12;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic                  cnv_a, sck_a, valid_a, busy_a;
  logic [NCH-1:0]        sdo_a;
  logic [NCH*DW_A-1:0]   data_a;
  logic [7:0]            ovr_a;

  logic                  cnv_b, sck_b, valid_b, busy_b;
  logic [NCH-1:0]        sdo_b;
  logic [NCH*DW_B-1:0]   data_b;
  logic [7:0]            ovr_b;

  int checks = 0;
  int errors = 0;

  int idx_a = 15;
  logic [15:0] wa;

  drac_adc_capture u_dut_a (
    .sysclk       (sysclk),
    .reset        (reset),
    .start        (start_a),
    .adc_cnv      (cnv_a),
    .adc_sck      (sck_a),
    .adc_sdo      (sdo_a),
    .sample_data  (data_a),
    .sample_valid (valid_a),
    .busy         (busy_a),
    .overrun_cnt  (ovr_a)
  );

  drac_adc_capture #(
    .NUM_CH       (NCH),
    .DATA_WIDTH   (DW_B),
    .CONV_CYCLES  (40),
    .QUIET_CYCLES (0),
    .SCK_HALF     (1)
  ) u_dut_b (
    .sysclk       (sysclk),
    .reset        (reset),
    .start        (start_b),
    .adc_cnv      (cnv_b),
    .adc_sck      (sck_b),
    .adc_sdo      (sdo_b),
    .sample_data  (data_b),
    .sample_valid (valid_b),
    .busy         (busy_b),
    .overrun_cnt  (ovr_b)
  );

  always #5 sysclk = ~sysclk;

  // ADC model for instance A: MSB presented after CNV, next bit after each SCK fall.
  always @(negedge sck_a or posedge cnv_a) begin
    if (cnv_a) idx_a = 15;
    else if (idx_a > 0) idx_a = idx_a - 1;
  end

  always_comb begin
    wa    = 16'h0000;
    sdo_a = '0;
    for (int k = 0; k < NCH; k++) begin
      wa       = 16'hA5A0 + 16'(k);
      sdo_a[k] = wa[idx_a[3:0]];
    end
  end

  assign sdo_b = '1;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic exp_busy, exp_cnv, exp_sck, prev_sck;
  int cnv_hi, sck_rise, valid_n, valid_cyc, v1, v2;
  int bad_busy, bad_cnv, bad_sck, bad_ovr;
  int acc, ign, exp_ovr;
  int busy_at_65, busy_at_66;

  initial begin
    // Reset state, viewed while reset is held.
    reset = 1'b1;
    repeat (3) step();
    check("rst_cnv",   cnv_a,   1'b0);
    check("rst_sck",   sck_a,   1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_data",  data_a,  160'd0);
    check("rst_ovr",   ovr_a,   8'd0);
    check("rst_b_busy", busy_b, 1'b0);
    reset = 1'b0;
    step();

    // Test 1: single capture, waveform shape and data.
    cnv_hi = 0; sck_rise = 0; valid_n = 0; valid_cyc = -1;
    bad_busy = 0; bad_cnv = 0; bad_sck = 0; prev_sck = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 115; c++) begin
      exp_busy = (c <= 107);
      exp_cnv  = (c <= 40);
      exp_sck  = (c >= 43) && (c <= 106) && (((c - 43) % 4) >= 2);
      if (busy_a !== exp_busy) bad_busy++;
      if (cnv_a  !== exp_cnv)  bad_cnv++;
      if (sck_a  !== exp_sck)  bad_sck++;
      if (cnv_a === 1'b1) cnv_hi++;
      if (sck_a === 1'b1 && prev_sck === 1'b0) sck_rise++;
      prev_sck = sck_a;
      if (valid_a === 1'b1) begin
        valid_n++;
        valid_cyc = c;
      end
      if (c == 107) begin
        for (int k = 0; k < NCH; k++) begin
          check($sformatf("t1_ch%0d", k), data_a[k*DW_A +: DW_A], 16'hA5A0 + 16'(k));
        end
      end
      step();
    end
    check("t1_valid_cycle", valid_cyc, 107);
    check("t1_valid_count", valid_n, 1);
    check("t1_busy_shape", bad_busy, 0);
    check("t1_cnv_shape", bad_cnv, 0);
    check("t1_sck_shape", bad_sck, 0);
    check("t1_cnv_high_cycles", cnv_hi, 40);
    check("t1_sck_rises", sck_rise, 16);

    // Test 2: starts at 0, 50, 107 (two ignored) and 108 (accepted).
    do_reset();
    valid_n = 0; v1 = -1; v2 = -1;
    for (int c = 0; c <= 230; c++) begin
      start_a = (c == 0) || (c == 50) || (c == 107) || (c == 108);
      step();
      start_a = 1'b0;
      if (valid_a === 1'b1) begin
        if (valid_n == 0) v1 = c + 1;
        else v2 = c + 1;
        valid_n++;
      end
    end
    check("t2_first_valid", v1, 107);
    check("t2_second_valid", v2, 215);
    check("t2_valid_count", valid_n, 2);
    check("t2_overrun", ovr_a, 8'd2);
    check("t2_ch0", data_a[0 +: DW_A], 16'hA5A0);
    check("t2_ch9", data_a[9*DW_A +: DW_A], 16'hA5A9);

    // Test 3: reset at cycle 70 (mid-shift, SCK high), no partial result.
    for (int c = 0; c < 70; c++) begin
      start_a = (c == 0);
      step();
      start_a = 1'b0;
    end
    check("t3_sck_before_rst", sck_a, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t3_sck", sck_a, 1'b0);
    check("t3_cnv", cnv_a, 1'b0);
    check("t3_busy", busy_a, 1'b0);
    check("t3_data", data_a, 160'd0);
    check("t3_ovr", ovr_a, 8'd0);
    valid_n = 0;
    for (int c = 0; c < 120; c++) begin
      if (valid_a === 1'b1) valid_n++;
      step();
    end
    check("t3_no_valid", valid_n, 0);
    valid_cyc = -1;
    for (int c = 0; c <= 110; c++) begin
      start_a = (c == 0);
      step();
      start_a = 1'b0;
      if (valid_a === 1'b1) valid_cyc = c + 1;
    end
    check("t3_restart_valid", valid_cyc, 107);
    check("t3_restart_ch3", data_a[3*DW_A +: DW_A], 16'hA5A3);

    // Test 4: 300 starts every 10 cycles; ignored count exceeds 255.
    do_reset();
    acc = -1000; ign = 0; bad_ovr = 0;
    for (int c = 0; c < 3000; c++) begin
      start_a = ((c % 10) == 0);
      if (start_a) begin
        if (c >= acc + 1 && c <= acc + 107) ign++;
        else acc = c;
      end
      step();
      start_a = 1'b0;
      exp_ovr = (ign > 255) ? 255 : ign;
      if (ovr_a !== 8'(exp_ovr)) bad_ovr++;
    end
    check("t4_ovr_track", bad_ovr, 0);
    check("t4_ovr_sat", ovr_a, 8'd255);
    for (int c = 0; c < 110; c++) step();
    start_a = 1'b1;
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("t4_ovr_no_wrap", ovr_a, 8'd255);
    for (int c = 0; c < 110; c++) step();

    // Test 5: instance B, DATA_WIDTH=12, SCK_HALF=1, QUIET_CYCLES=0.
    do_reset();
    check("t5_rst_data", data_b, 120'd0);
    valid_n = 0; valid_cyc = -1; busy_at_65 = -1; busy_at_66 = -1;
    for (int c = 0; c <= 70; c++) begin
      start_b = (c == 0);
      step();
      start_b = 1'b0;
      if (valid_b === 1'b1) begin
        valid_n++;
        valid_cyc = c + 1;
        check("t5_data_at_valid", data_b, {NCH{12'hFFF}});
      end
      if (c + 1 == 65) busy_at_65 = int'(busy_b);
      if (c + 1 == 66) busy_at_66 = int'(busy_b);
    end
    check("t5_valid_cycle", valid_cyc, 65);
    check("t5_valid_count", valid_n, 1);
    check("t5_busy_65", busy_at_65, 1);
    check("t5_busy_66", busy_at_66, 0);
    check("t5_ch9", data_b[9*DW_B +: DW_B], 12'hFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
